// File: rtl/frame_dump_uart_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_dump_uart_if
// Brief    : Shared frame-buffer read port between the dump engine (master)
//            and the RAM / display arbitration side (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface frame_dump_uart_if;
  logic        ram_req;    // dump engine wants the RAM port this cycle
  logic [14:0] ram_addr;   // pixel address, row-major
  logic [11:0] ram_rd;     // read data {R,G,B}, one cycle after the grant
  logic        screen_on;  // display scan-out owns the port when high

  modport master (output ram_req, ram_addr, input ram_rd, screen_on);
  modport slave  (input ram_req, ram_addr, output ram_rd, screen_on);
endinterface
`default_nettype wire

// File: rtl/frame_dump_uart.sv
`default_nettype none
// ============================================================================
// Module   : frame_dump_uart
// Brief    : Streams the frame buffer over UART 8N1: header A5 5A, then two
//            bytes per pixel ({4'h0,R} and {G,B}). Reads only while the
//            display is blanked.
// Revision : 1.0 - initial release
// ============================================================================
module frame_dump_uart #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          start,
  frame_dump_uart_if.master  ram,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int N            = WIDTH * HEIGHT;
  localparam logic [14:0]      LAST_PIX = 15'(N - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HDR0    = 3'd1;
  localparam logic [2:0] HDR1    = 3'd2;
  localparam logic [2:0] FETCH   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] SEND_HI = 3'd5;
  localparam logic [2:0] SEND_LO = 3'd6;
  localparam logic [2:0] FIN     = 3'd7;

  logic [2:0]       state;
  logic [14:0]      pix;
  logic [7:0]       pix_lo;

  // serializer: bit_idx 0 = start, 1..8 = data LSB first, 9 = stop
  logic             ser_active;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] baud_cnt;
  logic [7:0]       shreg;

  logic             ser_last;
  logic             load_en;
  logic [7:0]       load_byte;

  assign ser_last     = ser_active && (bit_idx == 4'd9) && (baud_cnt == LAST_CNT);
  assign ram.ram_req  = (state == FETCH);
  assign ram.ram_addr = pix;

  // Next byte to hand to the serializer; loading on ser_last keeps bytes gapless
  always_comb begin
    load_en   = 1'b0;
    load_byte = 8'h00;
    case (state)
      IDLE:    if (start)    begin load_en = 1'b1; load_byte = 8'hA5; end
      HDR0:    if (ser_last) begin load_en = 1'b1; load_byte = 8'h5A; end
      S_WAIT:  begin load_en = 1'b1; load_byte = {4'h0, ram.ram_rd[11:8]}; end
      SEND_HI: if (ser_last) begin load_en = 1'b1; load_byte = pix_lo; end
      default: ;
    endcase
  end

  // UART byte serializer; a new load always restarts at the start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx         <= 1'b1;
      ser_active <= 1'b0;
      bit_idx    <= 4'd0;
      baud_cnt   <= '0;
      shreg      <= 8'h00;
    end else if (load_en) begin
      tx         <= 1'b0;
      ser_active <= 1'b1;
      bit_idx    <= 4'd0;
      baud_cnt   <= '0;
      shreg      <= load_byte;
    end else if (ser_active) begin
      if (baud_cnt == LAST_CNT) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          ser_active <= 1'b0;
          tx         <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= (bit_idx == 4'd8) ? 1'b1 : shreg[bit_idx[2:0]];
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

  // Main sequencing: header, then fetch / hi / lo per pixel, then done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pix    <= 15'd0;
      pix_lo <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= HDR0;
          busy  <= 1'b1;
          pix   <= 15'd0;
        end
        HDR0:    if (ser_last) state <= HDR1;
        HDR1:    if (ser_last) state <= FETCH;
        FETCH:   if (!ram.screen_on) state <= S_WAIT;
        S_WAIT: begin
          pix_lo <= ram.ram_rd[7:0];
          state  <= SEND_HI;
        end
        SEND_HI: if (ser_last) state <= SEND_LO;
        SEND_LO: if (ser_last) begin
          if (pix == LAST_PIX) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            pix   <= pix + 15'd1;
            state <= FETCH;
          end
        end
        FIN: begin
          pix   <= 15'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_dump_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_dump_uart
// Brief    : Self-checking bench: small 2x2 frame at 4 clks/bit with a UART
//            decoder and expected-byte queue, plus bit timing at defaults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_dump_uart;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // small configuration: 2x2 frame, 4 clocks per bit
  logic rst_s, start_s, tx_s, busy_s, done_s;
  frame_dump_uart_if ifs();
  logic [11:0] mem [4];

  frame_dump_uart #(.CLK_HZ(4), .BAUD(1), .WIDTH(2), .HEIGHT(2)) dut_s (
    .clk(clk), .reset(rst_s), .start(start_s), .ram(ifs.master),
    .tx(tx_s), .busy(busy_s), .done(done_s)
  );

  // default configuration, used only for bit timing
  logic rst_d, start_d, tx_d, busy_d, done_d;
  frame_dump_uart_if ifd();

  frame_dump_uart dut_d (
    .clk(clk), .reset(rst_d), .start(start_d), .ram(ifd.master),
    .tx(tx_d), .busy(busy_d), .done(done_d)
  );

  // RAM model: data only meaningful when the block actually owns the port
  always @(posedge clk) begin
    if (ifs.ram_req && !ifs.screen_on) ifs.ram_rd <= mem[ifs.ram_addr[1:0]];
    else                               ifs.ram_rd <= 12'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // expected stream from the frame contents
  logic [7:0] exp_q [$];
  task automatic build_exp(output logic [7:0] q [$]);
    q = {};
    q.push_back(8'hA5);
    q.push_back(8'h5A);
    for (int i = 0; i < 4; i++) begin
      q.push_back({4'h0, mem[i][11:8]});
      q.push_back(mem[i][7:0]);
    end
  endtask

  // UART decoder for the small DUT, sampling mid-bit
  bit         dc_on = 1'b0;
  int         dc_cnt = 0;
  int         dc_nbytes = 0;
  initial begin
    logic [7:0] b;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_s) dc_on = 1'b0;
      else if (!dc_on) begin
        if (tx_s == 1'b0) begin dc_on = 1'b1; dc_cnt = 0; end
      end else dc_cnt++;
      if (dc_on && !rst_s) begin
        if (dc_cnt == 2) chk("start_bit", 32'(tx_s), 32'd0);
        else if (dc_cnt >= 6 && dc_cnt <= 34 && ((dc_cnt - 2) % 4) == 0)
          b[(dc_cnt - 2) / 4 - 1] = tx_s;
        else if (dc_cnt == 38) begin
          chk("stop_bit", 32'(tx_s), 32'd1);
          if (exp_q.size() == 0) fail("extra_byte");
          else chk("byte", 32'(b), 32'(exp_q.pop_front()));
          dc_nbytes++;
          dc_on = 1'b0;
        end
      end
    end
  end

  // per-cycle monitor: done shape, port usage, stream completeness
  int done_cnt = 0;
  initial begin
    bit prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_s) begin
        if (done_s) begin
          done_cnt++;
          chk("busy_at_done", 32'(busy_s), 32'd0);
          chk("bytes_left_at_done", 32'(exp_q.size()), 32'd0);
          if (prev_done) fail("done_width");
        end
        if (!busy_s) chk("req_when_idle", 32'(ifs.ram_req), 32'd0);
        if (ifs.ram_req) chk("addr_range", 32'(ifs.ram_addr < 15'd4), 32'd1);
        prev_done = done_s;
      end else prev_done = 1'b0;
    end
  end

  // random blanking pattern
  bit rand_en = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rand_en) ifs.screen_on = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic kick();
    dc_nbytes = 0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk("busy_after_start", 32'(busy_s), 32'd1);
    chk("tx_start_bit_begins", 32'(tx_s), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done_s && n < budget) begin @(negedge clk); n++; end
    if (!done_s) fail("done_timeout");
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [7:0] lit [$];
    logic [7:0] tmp [$];
    logic [9:0] expbits;
    logic [9:0] bits;
    int         base, first_high, n;

    rst_s = 1'b1; start_s = 1'b0; ifs.screen_on = 1'b0;
    rst_d = 1'b1; start_d = 1'b0; ifd.screen_on = 1'b0; ifd.ram_rd = 12'h000;
    for (int i = 0; i < 4; i++) mem[i] = 12'h000;
    repeat (5) @(negedge clk);

    // reset values
    chk("rst_tx", 32'(tx_s), 32'd1);
    chk("rst_busy", 32'(busy_s), 32'd0);
    chk("rst_done", 32'(done_s), 32'd0);
    chk("rst_req", 32'(ifs.ram_req), 32'd0);
    chk("rst_addr", 32'(ifs.ram_addr), 32'd0);
    rst_s = 1'b0;
    repeat (100) begin
      @(negedge clk);
      chk("idle_tx", 32'(tx_s), 32'd1);
      chk("idle_busy", 32'(busy_s), 32'd0);
    end

    // small frame with hand-computed stream
    mem[0] = 12'hF00; mem[1] = 12'h0F0; mem[2] = 12'h00F; mem[3] = 12'hABC;
    lit = {8'hA5, 8'h5A, 8'h0F, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h0F, 8'h0A, 8'hBC};
    build_exp(tmp);
    chk("model_pin", 32'(tmp == lit), 32'd1);
    exp_q = lit;
    done_cnt = 0;
    kick();
    wait_done(2000);
    chk("small_done_cnt", 32'(done_cnt), 32'd1);
    chk("small_nbytes", 32'(dc_nbytes), 32'd10);
    chk("idle_addr_after", 32'(ifs.ram_addr), 32'd0);

    // blanking stall during the second fetch
    build_exp(exp_q);
    done_cnt = 0;
    kick();
    n = 0;
    while (!(ifs.ram_req && ifs.ram_addr == 15'd1) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) fail("stall_fetch_timeout");
    ifs.screen_on = 1'b1;
    repeat (50) begin
      @(negedge clk);
      chk("stall_addr", 32'(ifs.ram_addr), 32'd1);
      chk("stall_tx", 32'(tx_s), 32'd1);
      chk("stall_req", 32'(ifs.ram_req), 32'd1);
    end
    ifs.screen_on = 1'b0;
    wait_done(2000);
    chk("stall_done_cnt", 32'(done_cnt), 32'd1);
    chk("stall_nbytes", 32'(dc_nbytes), 32'd10);

    // start while busy is ignored
    build_exp(exp_q);
    done_cnt = 0;
    kick();
    repeat (20) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    wait_done(2000);
    repeat (200) @(negedge clk);
    chk("rebusy_done_cnt", 32'(done_cnt), 32'd1);
    chk("rebusy_nbytes", 32'(dc_nbytes), 32'd10);

    // reset during D3 of the third byte (0x0F)
    build_exp(exp_q);
    done_cnt = 0;
    kick();
    n = 0;
    while (!(dc_nbytes == 2 && dc_on && dc_cnt >= 17) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) fail("reset_point_timeout");
    rst_s = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx_s), 32'd1);
    chk("midrst_busy", 32'(busy_s), 32'd0);
    chk("midrst_req", 32'(ifs.ram_req), 32'd0);
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
    exp_q = {};
    repeat (100) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    build_exp(exp_q);
    kick();
    wait_done(2000);
    chk("after_rst_done_cnt", 32'(done_cnt), 32'd1);
    chk("after_rst_nbytes", 32'(dc_nbytes), 32'd10);

    // randomized frames with random blanking
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 4; i++) mem[i] = 12'($urandom);
      build_exp(exp_q);
      done_cnt = 0;
      rand_en = 1'b1;
      kick();
      wait_done(5000);
      rand_en = 1'b0;
      ifs.screen_on = 1'b0;
      chk("rand_done_cnt", 32'(done_cnt), 32'd1);
      chk("rand_nbytes", 32'(dc_nbytes), 32'd10);
    end

    // bit timing at default parameters: frame of 0xA5
    expbits = 10'b1101001010;
    bits = 10'h000;
    rst_d = 1'b0;
    @(negedge clk);
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    chk("dflt_busy", 32'(busy_d), 32'd1);
    first_high = -1;
    base = 0;
    while (base <= 9 * 868 + 434) begin
      if (tx_d !== 1'b0 && first_high < 0) first_high = base;
      if ((base % 868) == 434) bits[base / 868] = tx_d;
      @(negedge clk);
      base++;
    end
    chk("start_bit_width", 32'(first_high), 32'd868);
    for (int i = 0; i < 10; i++) chk("frame_bit", 32'(bits[i]), 32'(expbits[i]));
    rst_d = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_dump_uart.md
# frame_dump_uart

Reads the 160×120 picture back out of the frame buffer RAM and streams it over a UART TX line, so a drawing can be saved on a host PC. The top level writes the RAM from the cursor and the clear engine; this block is the opposite end of that interface. It shares the RAM port with the display scan-out and only reads during blanking (screen_on low). While it is active, `busy` is used at the top level to gate off cursor writes.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer division (868 at defaults)
- width, 160, pixels per line
- height, 120, lines per frame; pixel count N = width*height (19200)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request to begin a dump
- screen_on  in  1  display owns the RAM port when high
- ram_rd  in  12  RAM read data {R[11:8],G[7:4],B[3:0]}
- ram_req  out  1  block wants the RAM port this cycle
- ram_addr  out  15  read address, 0..N-1
- tx  out  1  UART line, 8N1, LSB first, idles high
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when the last stop bit completes

## Operation
- Stream format, in order:
  - Sync header 0xA5, then 0x5A.
  - For each address 0..N-1 (row-major), two bytes: hi = {4'h0, rgb[11:8]}, lo = rgb[7:0].
  - Total 2 + 2N bytes (38402 at defaults).
- Main FSM states and transitions:
  - IDLE: start → HDR0 (set busy).
  - HDR0: send 0xA5 → HDR1.
  - HDR1: send 0x5A → FETCH.
  - FETCH: assert ram_req with ram_addr = pix. On a grant cycle (ram_req=1 and screen_on=0) → WAIT.
  - WAIT: capture ram_rd into pix_reg → SEND_HI.
  - SEND_HI: send hi byte → SEND_LO.
  - SEND_LO: send lo byte. If pix == N-1 → FIN; else pix+1 → FETCH.
  - FIN: pulse done, clear busy → IDLE.
- Byte serializer sub-FSM: START (tx=0) → D0..D7 (tx = bit i) → STOP (tx=1). Each bit lasts exactly CLKS_PER_BIT cycles. The main FSM advances on the cycle after STOP expires.
- ram_req is high only in FETCH. ram_addr holds pix in all states; it is 0 in IDLE.
- pix is a 15-bit counter. It never exceeds N-1 and never wraps within a dump.
- start while busy is ignored, including in the FIN cycle.
- The block never drives a RAM write. The top level must force we=0 whenever ram_req is high.

## Timing
- Reset values: tx=1, ram_req=0, ram_addr=0, busy=0, done=0, FSM=IDLE, pix=0, baud counter=0.
- Reset mid-dump: tx returns high immediately (asynchronously). A partial byte is abandoned. No done pulse.
- start is sampled on a rising edge in IDLE. busy is high on the next cycle, and the start bit of 0xA5 begins the same cycle.
- RAM read latency is 1 cycle. Data from a grant at edge k is valid and captured at edge k+1.
- If screen_on is high in FETCH, the block waits with ram_req held and the address stable. There is no timeout.
- Back-to-back bytes: the start bit of the next byte follows the previous stop bit with at most 3 idle-high cycles. Idle cycles occur only around FETCH/WAIT, plus any screen_on stall.
- done asserts in the cycle after the final stop bit ends. busy falls in that same cycle.
- Minimum dump time: (2 + 2N) × 10 × CLKS_PER_BIT cycles, plus fetch overhead and stalls.

## Test plan
- Reset idle: hold reset, then release with no start → tx=1, busy=0, ram_req=0 for 100 cycles.
- Small frame with width=2, height=2, CLK_HZ=4, BAUD=1 (4 clks/bit), screen_on=0, RAM preloaded {0xF00, 0x0F0, 0x00F, 0xABC}:
  - tx must decode to A5 5A 0F 00 00 F0 00 0F 0A BC.
  - done is a single pulse; busy drops in the same cycle.
- screen_on stall (same config): hold screen_on=1 for 50 cycles during the 2nd FETCH → ram_addr stays 1, tx stays high, byte stream unchanged.
- start while busy: pulse start mid-header → stream identical to the small-frame case, exactly one done.
- Reset mid-operation: assert reset during D3 of byte 0x0F → tx=1 within the same cycle, busy=0, no done. A following start produces the full stream from 0xA5.
- Bit timing at defaults: measure the start-bit width of 0xA5 → exactly 868 cycles; tx frame bits read 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
